// File: rtl/rnd_pkg.sv
// Shared types and LFSR helpers for the multi-lane mantissa rounder.
package rnd_pkg;

  typedef enum logic [1:0] {
    RND_TRUNC = 2'b00,
    RND_RNE   = 2'b01,
    RND_STC   = 2'b10,
    RND_RHA   = 2'b11
  } rnd_mode_e;

  // Fibonacci maximal-length tap masks; bit n-1 set means tap n.
  function automatic logic [15:0] lfsr_taps(input int width);
    case (width)
      4:       return 16'h000C;
      5:       return 16'h0014;
      6:       return 16'h0030;
      7:       return 16'h0060;
      8:       return 16'h00B8;
      9:       return 16'h0110;
      10:      return 16'h0240;
      11:      return 16'h0500;
      12:      return 16'h0829;
      13:      return 16'h100D;
      14:      return 16'h2015;
      15:      return 16'h6000;
      16:      return 16'hD008;
      default: return 16'h000C;
    endcase
  endfunction

  // An all-zero state would lock the LFSR, so it is replaced by 1.
  function automatic logic [15:0] lfsr_fix_zero(input logic [15:0] v, input int width);
    logic [15:0] m;
    m = 16'hFFFF >> (16 - width);
    return ((v & m) == 16'd0) ? 16'd1 : (v & m);
  endfunction

endpackage

// File: rtl/rnd_lane_dec.sv
// Combinational increment decision for one rounding lane.
module rnd_lane_dec
  import rnd_pkg::*;
#(
  parameter int REST_W  = 20,
  parameter int NOISE_W = 6
) (
  input  logic               keep_lsb,
  input  logic [REST_W-1:0]  rest,
  input  rnd_mode_e          mode,
  input  logic [NOISE_W-1:0] noise,
  output logic               inc
);

  logic               guard;
  logic               sticky;
  logic [NOISE_W-1:0] r;
  logic [NOISE_W:0]   stc_sum;

  assign guard = rest[REST_W-1];

  generate
    if (REST_W > 1) begin : g_sticky
      assign sticky = |rest[REST_W-2:0];
    end else begin : g_no_sticky
      assign sticky = 1'b0;
    end

    if (REST_W >= NOISE_W) begin : g_r_slice
      assign r = rest[REST_W-1 -: NOISE_W];
    end else begin : g_r_pad
      assign r = {rest, {(NOISE_W-REST_W){1'b0}}};
    end
  endgenerate

  assign stc_sum = {1'b0, r} + {1'b0, noise};

  always_comb begin
    // NOTE: default first so every path assigns inc and no latch is inferred.
    inc = 1'b0;
    case (mode)
      RND_TRUNC: inc = 1'b0;
      RND_RNE:   inc = guard & (sticky | keep_lsb);
      RND_STC:   inc = stc_sum[NOISE_W];
      RND_RHA:   inc = guard;
      default:   inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/rnd_multi_lane.sv
// Multi-lane, mode-selectable mantissa rounder with per-lane LFSR noise
// and a 2-stage valid/ready pipeline (decision stage, add/saturate stage).
module rnd_multi_lane
  import rnd_pkg::*;
#(
  parameter int LANES   = 4,
  parameter int WIDTH_I = 24,
  parameter int WIDTH_O = 4,
  parameter int NOISE_W = 6,
  parameter int SAT     = 1,
  parameter int SEED    = 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_vld,
  output logic                     o_rdy,
  input  logic [LANES*WIDTH_I-1:0] i_num,
  input  logic [1:0]               i_mode,
  input  logic                     i_seed_vld,
  input  logic [NOISE_W-1:0]       i_seed,
  output logic                     o_vld,
  input  logic                     i_rdy,
  output logic [LANES*WIDTH_O-1:0] o_man,
  output logic [LANES-1:0]         o_ofl
);

  localparam int REST_W = WIDTH_I - WIDTH_O;
  localparam logic [NOISE_W-1:0] TAPS = NOISE_W'(lfsr_taps(NOISE_W));

  logic                     s1_vld_q, s1_vld_d;
  logic [WIDTH_O-1:0]       s1_keep_q [LANES];
  logic [WIDTH_O-1:0]       s1_keep_d [LANES];
  logic [LANES-1:0]         s1_inc_q, s1_inc_d;
  logic                     s2_vld_q, s2_vld_d;
  logic [LANES*WIDTH_O-1:0] man_q, man_d;
  logic [LANES-1:0]         ofl_q, ofl_d;
  logic [NOISE_W-1:0]       lfsr_q [LANES];
  logic [NOISE_W-1:0]       lfsr_d [LANES];
  logic [LANES-1:0]         inc_w;
  logic [WIDTH_O:0]         sum;
  logic                     s2_adv;
  logic                     accept;

  // Ready depends only on registered state and i_rdy, never on i_vld.
  assign s2_adv = !s2_vld_q | i_rdy;
  assign o_rdy  = !s1_vld_q | s2_adv;
  assign accept = i_vld & o_rdy;

  assign o_vld = s2_vld_q;
  assign o_man = man_q;
  assign o_ofl = ofl_q;

  generate
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      rnd_lane_dec #(
        .REST_W  (REST_W),
        .NOISE_W (NOISE_W)
      ) u_dec (
        .keep_lsb (i_num[k*WIDTH_I + REST_W]),
        .rest     (i_num[k*WIDTH_I +: REST_W]),
        .mode     (rnd_mode_e'(i_mode)),
        .noise    (lfsr_q[k]),
        .inc      (inc_w[k])
      );
    end
  endgenerate

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_keep_d = s1_keep_q;
    s1_inc_d  = s1_inc_q;
    s2_vld_d  = s2_vld_q;
    man_d     = man_q;
    ofl_d     = ofl_q;
    lfsr_d    = lfsr_q;
    sum       = '0;

    if (o_rdy) s1_vld_d = i_vld;
    if (accept) begin
      for (int k = 0; k < LANES; k++) begin
        s1_keep_d[k] = i_num[k*WIDTH_I + REST_W +: WIDTH_O];
      end
      s1_inc_d = inc_w;
    end

    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        for (int k = 0; k < LANES; k++) begin
          sum      = {1'b0, s1_keep_q[k]} + (WIDTH_O+1)'(s1_inc_q[k]);
          ofl_d[k] = sum[WIDTH_O];
          man_d[k*WIDTH_O +: WIDTH_O] = ((SAT != 0) && sum[WIDTH_O]) ?
                                        {WIDTH_O{1'b1}} : sum[WIDTH_O-1:0];
        end
      end
    end

    // Seed load wins over an advance; the beat accepted now already used lfsr_q.
    for (int k = 0; k < LANES; k++) begin
      if (i_seed_vld) begin
        lfsr_d[k] = NOISE_W'(lfsr_fix_zero(16'(i_seed) ^ 16'(k + 1), NOISE_W));
      end else if (accept) begin
        lfsr_d[k] = {lfsr_q[k][NOISE_W-2:0], ^(lfsr_q[k] & TAPS)};
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments; the small data
  // arrays are reset too so outputs read as zero straight out of reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_vld_q <= 1'b0;
      s1_inc_q <= '0;
      s2_vld_q <= 1'b0;
      man_q    <= '0;
      ofl_q    <= '0;
      for (int k = 0; k < LANES; k++) begin
        s1_keep_q[k] <= '0;
        lfsr_q[k]    <= NOISE_W'(lfsr_fix_zero(16'(SEED) ^ 16'(k + 1), NOISE_W));
      end
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_keep_q <= s1_keep_d;
      s1_inc_q  <= s1_inc_d;
      s2_vld_q  <= s2_vld_d;
      man_q     <= man_d;
      ofl_q     <= ofl_d;
      lfsr_q    <= lfsr_d;
    end
  end

endmodule
